// File: rtl/seg_scan4_if.sv
// Load-side and display-side signals of the four-digit seven-segment scanner.
interface seg_scan4_if;
    logic       load;
    logic [6:0] d0;
    logic [6:0] d1;
    logic [6:0] d2;
    logic [6:0] d3;
    logic [3:0] dig_en;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic       frame_start;
    logic       pending;

    modport master (
        output load, d0, d1, d2, d3, dig_en,
        input  seg_n, an_n, frame_start, pending
    );

    modport slave (
        input  load, d0, d1, d2, d3, dig_en,
        output seg_n, an_n, frame_start, pending
    );
endinterface

// File: rtl/seg_scan4.sv
// Four-digit seven-segment scanner: blanked time-multiplexing with
// double-buffered codes that commit only at frame boundaries.
module seg_scan4 #(
    parameter int unsigned DIGIT_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan4_if.slave  bus
);
    localparam int unsigned CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [6:0]    SEG_OFF   = 7'h7F;
    localparam logic [3:0]    AN_OFF    = 4'hF;

    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:0]      slot, slot_nxt;
    logic [3:0][6:0] act_code, act_code_nxt;
    logic [3:0]      act_en, act_en_nxt;
    logic [3:0][6:0] pend_code, pend_code_nxt;
    logic [3:0]      pend_en, pend_en_nxt;
    logic            pending, pending_nxt;
    logic [6:0]      seg_q, seg_nxt;
    logic [3:0]      an_q, an_nxt;
    logic            fs_q, fs_nxt;
    logic            slot_end;
    logic            frame_end;
    logic [3:0][6:0] in_code;

    assign in_code   = {bus.d3, bus.d2, bus.d1, bus.d0};
    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (slot == 2'd3);

    // Next-state for counters, buffers and the registered display outputs.
    always_comb begin
        cnt_nxt       = slot_end ? '0 : cnt + CW'(1);
        slot_nxt      = slot_end ? slot + 2'd1 : slot;
        act_code_nxt  = act_code;
        act_en_nxt    = act_en;
        pend_code_nxt = pend_code;
        pend_en_nxt   = pend_en;
        pending_nxt   = pending;
        seg_nxt       = SEG_OFF;
        an_nxt        = AN_OFF;

        if (bus.load) begin
            pend_code_nxt = in_code;
            pend_en_nxt   = bus.dig_en;
        end

        // A load coinciding with the boundary bypasses the pending stage.
        if (frame_end) begin
            pending_nxt = 1'b0;
            if (bus.load) begin
                act_code_nxt = in_code;
                act_en_nxt   = bus.dig_en;
            end else if (pending) begin
                act_code_nxt = pend_code;
                act_en_nxt   = pend_en;
            end
        end else if (bus.load) begin
            pending_nxt = 1'b1;
        end

        if ((cnt_nxt >= CNT_BLANK) && act_en_nxt[slot_nxt]) begin
            an_nxt  = ~(4'b0001 << slot_nxt);
            seg_nxt = act_code_nxt[slot_nxt];
        end

        fs_nxt = (slot_nxt == 2'd0) && (cnt_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            slot      <= 2'd0;
            act_code  <= {4{SEG_OFF}};
            act_en    <= 4'b0000;
            pend_code <= {4{SEG_OFF}};
            pend_en   <= 4'b0000;
            pending   <= 1'b0;
            seg_q     <= SEG_OFF;
            an_q      <= AN_OFF;
            fs_q      <= 1'b1;
        end else begin
            cnt       <= cnt_nxt;
            slot      <= slot_nxt;
            act_code  <= act_code_nxt;
            act_en    <= act_en_nxt;
            pend_code <= pend_code_nxt;
            pend_en   <= pend_en_nxt;
            pending   <= pending_nxt;
            seg_q     <= seg_nxt;
            an_q      <= an_nxt;
            fs_q      <= fs_nxt;
        end
    end

    assign bus.seg_n       = seg_q;
    assign bus.an_n        = an_q;
    assign bus.frame_start = fs_q;
    assign bus.pending     = pending;
endmodule

// File: tb/tb_seg_scan4.sv
// Directed bench for seg_scan4 with DIGIT_CYCLES = 8, BLANK_CYCLES = 2.
module tb_seg_scan4;
    localparam int unsigned D = 8;
    localparam int unsigned B = 2;
    localparam int unsigned F = 4 * D;

    logic clk;
    logic rst;
    seg_scan4_if bus();

    seg_scan4 #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Per-test expectations: active set per frame, pending per cycle, load schedule.
    logic [3:0]  fr_en   [0:3];
    logic [27:0] fr_code [0:3];
    bit          exp_pend[0:127];
    int          ld_at   [0:2];
    logic [27:0] ld_code [0:2];
    logic [3:0]  ld_en   [0:2];
    int          n_ld;

    localparam logic [27:0] BASIC = {7'h42, 7'h68, 7'h71, 7'h30};
    localparam logic [27:0] ZEROS = {7'h00, 7'h00, 7'h00, 7'h00};
    localparam logic [27:0] ALL3F = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
    localparam logic [27:0] BOUND = {7'h7F, 7'h7F, 7'h7F, 7'h12};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_test();
        for (int i = 0; i < 4; i++) begin
            fr_en[i]   = 4'b0000;
            fr_code[i] = {4{7'h7F}};
        end
        for (int i = 0; i < 128; i++) exp_pend[i] = 1'b0;
        n_ld = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.load = 1'b0;
        repeat (3) step();
        check("rst_seg", 32'(bus.seg_n), 32'h7F);
        check("rst_an", 32'(bus.an_n), 32'hF);
        check("rst_pend", 32'(bus.pending), 32'h0);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check_cycle();
        int f, sl, k;
        logic [3:0]  en;
        logic [27:0] codes;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        f     = cyc / F;
        sl    = (cyc % F) / D;
        k     = cyc % D;
        en    = fr_en[f];
        codes = fr_code[f];
        e_an  = 4'hF;
        e_seg = 7'h7F;
        if (k >= B && en[sl]) begin
            e_an  = ~(4'b0001 << sl);
            e_seg = codes[sl*7 +: 7];
        end
        check("an_n", 32'(bus.an_n), 32'(e_an));
        check("seg_n", 32'(bus.seg_n), 32'(e_seg));
        check("pending", 32'(bus.pending), 32'(exp_pend[cyc]));
        check("frame_start", 32'(bus.frame_start), 32'((cyc % F) == 0));
    endtask

    task automatic run(input int last);
        forever begin
            bus.load = 1'b0;
            for (int i = 0; i < n_ld; i++) begin
                if (ld_at[i] == cyc) begin
                    bus.load   = 1'b1;
                    bus.d0     = ld_code[i][6:0];
                    bus.d1     = ld_code[i][13:7];
                    bus.d2     = ld_code[i][20:14];
                    bus.d3     = ld_code[i][27:21];
                    bus.dig_en = ld_en[i];
                end
            end
            check_cycle();
            if (cyc >= last) break;
            step();
        end
        bus.load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.load = 1'b0;
        bus.d0 = '0; bus.d1 = '0; bus.d2 = '0; bus.d3 = '0;
        bus.dig_en = '0;
        @(negedge clk);

        // Reset only: nothing lights, frame_start every 32 cycles.
        clear_test();
        do_reset();
        run(64);

        // Basic scan followed by two mid-frame reloads (last load wins).
        clear_test();
        fr_en[1] = 4'hF; fr_code[1] = BASIC;
        fr_en[2] = 4'hF; fr_code[2] = BASIC;
        fr_en[3] = 4'hF; fr_code[3] = ALL3F;
        for (int i = 2; i <= 31; i++) exp_pend[i] = 1'b1;
        for (int i = 71; i <= 95; i++) exp_pend[i] = 1'b1;
        ld_at[0] = 1;  ld_code[0] = BASIC; ld_en[0] = 4'hF;
        ld_at[1] = 70; ld_code[1] = ZEROS; ld_en[1] = 4'hF;
        ld_at[2] = 80; ld_code[2] = ALL3F; ld_en[2] = 4'hF;
        n_ld = 3;
        do_reset();
        run(127);

        // Mask 0101: slots 1 and 3 stay dark.
        clear_test();
        fr_en[1] = 4'b0101; fr_code[1] = BASIC;
        for (int i = 2; i <= 31; i++) exp_pend[i] = 1'b1;
        ld_at[0] = 1; ld_code[0] = BASIC; ld_en[0] = 4'b0101;
        n_ld = 1;
        do_reset();
        run(63);

        // Load on the frame-boundary edge goes straight to active.
        clear_test();
        fr_en[1] = 4'b0001; fr_code[1] = BOUND;
        ld_at[0] = 31; ld_code[0] = BOUND; ld_en[0] = 4'b0001;
        n_ld = 1;
        do_reset();
        run(40);

        // Reset in the middle of a lit slot discards everything.
        clear_test();
        fr_en[1] = 4'hF; fr_code[1] = BASIC;
        for (int i = 2; i <= 31; i++) exp_pend[i] = 1'b1;
        ld_at[0] = 1; ld_code[0] = BASIC; ld_en[0] = 4'hF;
        n_ld = 1;
        do_reset();
        run(36);
        rst = 1'b1;
        bus.load = 1'b1;
        bus.dig_en = 4'hF;
        step();
        check("midrst_an", 32'(bus.an_n), 32'hF);
        check("midrst_seg", 32'(bus.seg_n), 32'h7F);
        check("midrst_pend", 32'(bus.pending), 32'h0);
        step();
        bus.load = 1'b0;
        rst = 1'b0;
        cyc = 0;
        clear_test();
        run(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_scan4.md
# seg_scan4

Four-digit seven-segment display scanner that sits directly downstream of the effect-status segment encoder. It accepts four active-low 7-bit segment codes plus a per-digit enable mask through a load strobe. It time-multiplexes them onto one shared cathode bus with a rotating active-low anode strobe, inserting a blanking interval before each digit to suppress ghosting. New codes are double-buffered and take effect only at a frame boundary, so the display never shows a half-updated frame.

## Interface
- DIGIT_CYCLES, 50000, clock cycles per digit slot (1 ms at 50 MHz); must be ≥ 2
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes and segments off; 1 ≤ BLANK_CYCLES < DIGIT_CYCLES
- clk  in  1  system clock; only clock in the block
- rst  in  1  synchronous, active-high reset
- load  in  1  single-cycle strobe; captures d0..d3 and dig_en into the pending buffer
- d0, d1, d2, d3  in  7 each  active-low segment codes for digits 0..3; bit order passed through unchanged
- dig_en  in  4  bit i = 1 enables digit i
- seg_n  out  7  shared active-low cathodes, registered
- an_n  out  4  active-low anodes, registered; bit i drives digit i
- frame_start  out  1  high for the single cycle in which slot = 0 and cnt = 0
- pending  out  1  high while loaded data awaits commit

## Operation
- Counters: cnt runs 0..DIGIT_CYCLES-1; slot runs 0..3 and advances when cnt wraps. slot wraps 3→0. Frame length is 4·DIGIT_CYCLES cycles.
- Phases within a slot:
  - BLANK while cnt < BLANK_CYCLES: an_n = 4'hF, seg_n = 7'h7F.
  - SHOW while cnt ≥ BLANK_CYCLES: if active_en[slot] = 1, an_n = ~(4'b0001 << slot) and seg_n = active_code[slot]. Otherwise an_n = 4'hF and seg_n = 7'h7F.
- A disabled digit still consumes its full slot. Frame timing is independent of the mask.
- Buffers:
  - pending buffer: 4×7 codes + 4-bit enable.
  - active buffer: the same set, and the only source for seg_n/an_n.
- Load: on an edge with load = 1, the pending buffer takes d0..d3 and dig_en, and pending goes to 1. A later load before commit overwrites the earlier one (last load wins).
- Commit: on the edge that moves from (slot 3, cnt DIGIT_CYCLES-1) to (slot 0, cnt 0), if pending = 1, active ← pending and pending ← 0.
  - If load = 1 on that same edge, the input values are written straight into active, and pending ends 0.
- The active buffer never changes at any other time.
- Reset values: cnt = 0, slot = 0, seg_n = 7'h7F, an_n = 4'hF, pending = 0, active codes all 7'h7F, active_en = 4'b0000, pending buffer = 7'h7F / 4'b0000.
- Reset mid-operation: on the next edge all of the above values are restored, and any pending data is discarded. No commit happens on release from reset.
- load during rst is ignored.

## Timing
- seg_n/an_n are registered and reflect the (slot, cnt) held in the same cycle; the implementation computes them from next-state.
- No anode is ever low during BLANK. Two anodes are never low in the same cycle.
- Cycle numbering: cycle 0 is the first cycle after rst falls. Cycle 0 has slot 0, cnt 0, and frame_start = 1.
- Digit i is lit in cycles [i·D + B, (i+1)·D − 1] of each frame, where D = DIGIT_CYCLES and B = BLANK_CYCLES.
- Load-to-display latency: the commit occurs at the next frame boundary. The first lit cycle is B cycles after that boundary if digit 0 is enabled.
- pending rises the cycle after the load edge. It falls in the cycle that starts the new frame.
- Worst case, when the load lands at slot 0, cnt 0, the data waits one full frame.

## Test plan
All scenarios use DIGIT_CYCLES = 8 and BLANK_CYCLES = 2.
- Reset: hold rst for 3 cycles, then release. Required: seg_n = 7F, an_n = F and pending = 0 throughout; frame_start pulses at cycles 0, 32 and 64; no anode goes low.
- Basic scan: load at cycle 1 with d0 = 30, d1 = 71, d2 = 68, d3 = 42, dig_en = F. Required:
  - pending = 1 for cycles 2..31.
  - an_n = E / seg_n = 30 for cycles 34–39.
  - an_n = D / seg_n = 71 for cycles 42–47.
  - an_n = B / seg_n = 68 for cycles 50–55.
  - an_n = 7 / seg_n = 42 for cycles 58–63.
  - Blank in cycles 32–33 and 40–41.
- Mask: as the basic scan but dig_en = 0101. Required: an_n is never D or 7; slots 1 and 3 stay F/7F.
- Mid-frame reload: after the basic scan is running, load codes all 00 at cycle 70, then codes all 3F at cycle 80. Required: the displayed codes are unchanged through cycle 95; from cycle 98, digit 0 shows 3F; 00 never appears.
- Boundary load: assert load on the cycle at slot 3, cnt 7 (cycle 31) with d0 = 12. Required: pending stays 0; seg_n = 12 with an_n = E in cycles 34–39.
- Reset mid-SHOW: assert rst at cycle 36 during the basic scan, then release. Required: blank outputs from the next cycle; after release, nothing lights for the full frame because active_en = 0.
